// File: rtl/pose_judge_if.sv
// pose_judge_if: board-side and judge-side signals of the pose judge.
//   btn_left, btn_right : raw arm switches (1 = arm up)
//   boss_pose           : boss pose code (11 UP, 00 DOWN, 10 LEFTUP, 01 RIGHTUP)
//   right, miss         : match strobe / round-timeout pulse
//   player_pose         : debounced {left,right} pose
//   busy                : judge in PULSE or SETTLE
//   streak, best        : present only with POSE_JUDGE_STREAK_EN
// slave is the judge; master is whatever drives the switches/boss pose.
interface pose_judge_if;
   logic       btn_left;
   logic       btn_right;
   logic [1:0] boss_pose;
   logic       right;
   logic       miss;
   logic [1:0] player_pose;
   logic       busy;
`ifdef POSE_JUDGE_STREAK_EN
   logic [7:0] streak;
   logic [7:0] best;
   modport slave  (input  btn_left, btn_right, boss_pose,
                   output right, miss, player_pose, busy, streak, best);
   modport master (output btn_left, btn_right, boss_pose,
                   input  right, miss, player_pose, busy, streak, best);
`else
   modport slave  (input  btn_left, btn_right, boss_pose,
                   output right, miss, player_pose, busy);
   modport master (output btn_left, btn_right, boss_pose,
                   input  right, miss, player_pose, busy);
`endif
endinterface

// File: rtl/pose_judge.sv
// pose_judge: debounces the two arm switches into player_pose, compares it with the
// boss pose and emits a `right` strobe after the pose has been held long enough, or a
// one-cycle `miss` when the round runs out.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : pose_judge_if.slave (switches, boss_pose in; right/miss/player_pose/busy out)
// Optional feature macro POSE_JUDGE_STREAK_EN adds bus.streak / bus.best (match streak
// counter, saturating at 255, and its running maximum).
module pose_judge #(
   parameter int DEB_CYCLES   = 25000,
   parameter int HOLD_CYCLES  = 50000,
   parameter int ROUND_CYCLES = 50_000_000,
   parameter int PULSE_CYCLES = 4,
   parameter int SETTLE_MAX   = 1000
) (
   input logic        clk,
   input logic        reset,
   pose_judge_if.slave bus
);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(ROUND_CYCLES + 1);
   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam int SW = $clog2(SETTLE_MAX + 1);

   localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] ROUND_LAST  = RW'(ROUND_CYCLES - 1);
   localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_MAX - 1);

   typedef enum logic [1:0] {WAIT, PULSE, SETTLE} state_t;

   // index 1 = left arm, 0 = right arm, so `stable` is already the pose code
   logic [1:0]    sync1, sync2, stable;
   logic [DW-1:0] deb_cnt [2];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         stable  <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= {bus.btn_left, bus.btn_right};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            // any agreement with the accepted value restarts the stability count
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign bus.player_pose = stable;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] round_cnt;
   logic [PW-1:0] pulse_cnt;
   logic [SW-1:0] settle_cnt;
   logic [1:0]    pose_q;
   logic          right_q, miss_q, busy_q;
   logic          match, hit, timeout;

   assign match   = (stable == bus.boss_pose);
   // a completed hold beats a simultaneous timeout
   assign hit     = (state == WAIT) && match && (hold_cnt == HOLD_LAST);
   assign timeout = (state == WAIT) && !hit && (round_cnt == ROUND_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= WAIT;
         hold_cnt   <= '0;
         round_cnt  <= '0;
         pulse_cnt  <= '0;
         settle_cnt <= '0;
         pose_q     <= '0;
         right_q    <= 1'b0;
         miss_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         miss_q <= 1'b0;
         case (state)
            WAIT: begin
               if (hit) begin
                  state     <= PULSE;
                  right_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  pose_q    <= bus.boss_pose;
                  hold_cnt  <= '0;
                  round_cnt <= '0;
                  pulse_cnt <= '0;
               end else if (timeout) begin
                  miss_q    <= 1'b1;
                  hold_cnt  <= '0;
                  round_cnt <= '0;
               end else begin
                  round_cnt <= round_cnt + 1'b1;
                  hold_cnt  <= match ? hold_cnt + 1'b1 : '0;
               end
            end
            PULSE: begin
               if (pulse_cnt == PULSE_LAST) begin
                  state      <= SETTLE;
                  right_q    <= 1'b0;
                  pulse_cnt  <= '0;
                  settle_cnt <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + 1'b1;
               end
            end
            SETTLE: begin
               // wait for the boss to move on so one held pose is not scored twice
               if (bus.boss_pose != pose_q || settle_cnt == SETTLE_LAST) begin
                  state      <= WAIT;
                  busy_q     <= 1'b0;
                  settle_cnt <= '0;
                  hold_cnt   <= '0;
                  round_cnt  <= '0;
                  pulse_cnt  <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            default: begin
               state   <= WAIT;
               right_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.right = right_q;
   assign bus.miss  = miss_q;
   assign bus.busy  = busy_q;

`ifdef POSE_JUDGE_STREAK_EN
   logic [7:0] streak_q, best_q, streak_inc;

   assign streak_inc = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         streak_q <= '0;
         best_q   <= '0;
      end else if (hit) begin
         streak_q <= streak_inc;
         if (streak_inc > best_q) best_q <= streak_inc;
      end else if (timeout) begin
         streak_q <= '0;
      end
   end

   assign bus.streak = streak_q;
   assign bus.best   = best_q;
`endif
endmodule

// File: tb/tb_pose_judge.sv
// tb_pose_judge: directed scenarios plus randomized pose rounds for pose_judge, with
// expected timings derived from the debounce/hold/round/pulse/settle rules.
module tb_pose_judge;
   localparam int DEB    = 4;
   localparam int HOLD   = 8;
   localparam int ROUND  = 100;
   localparam int PULSE  = 2;
   localparam int SETTLE = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pose_judge_if bus ();

   pose_judge #(
      .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .ROUND_CYCLES(ROUND),
      .PULSE_CYCLES(PULSE), .SETTLE_MAX(SETTLE)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic seen_right, seen_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock edge, sampled 1 time unit later; cyc counts edges since reset release
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      seen_right = seen_right | bus.right;
      seen_miss  = seen_miss | bus.miss;
   endtask

   task automatic go(input int e);
      while (cyc < e) tick();
   endtask

   task automatic do_reset(input logic bl, input logic br, input logic [1:0] boss, input int n);
      reset = 1'b1;
      bus.btn_left = bl;
      bus.btn_right = br;
      bus.boss_pose = boss;
      repeat (n) tick();
      reset = 1'b0;
      cyc = 0;
      seen_right = 1'b0;
      seen_miss = 1'b0;
   endtask

   // Edge (after reset release) at which `right` rises, with the buttons already at pose p
   // during reset: pose 00 is valid from the start, any other pose lands after 2+DEB edges,
   // and a match then needs HOLD edges. -1 means no match ever.
   function automatic int exp_right_edge(input logic [1:0] p, input logic [1:0] b);
      if (p != b) return -1;
      return (p == 2'b00) ? HOLD : 2 + DEB + HOLD;
   endfunction

   initial begin
      int       t0;
      int       re;
      int       s;
      int       k;
      logic     bad;
      logic [1:0] p, b;

      // 1: reset with both arms up
      do_reset(1'b1, 1'b1, 2'b10, 3);
      chk("rst_right", bus.right, 0);
      chk("rst_miss", bus.miss, 0);
      chk("rst_pose", bus.player_pose, 0);
      chk("rst_busy", bus.busy, 0);
`ifdef POSE_JUDGE_STREAK_EN
      chk("rst_streak", bus.streak, 0);
      chk("rst_best", bus.best, 0);
`endif
      go(2 + DEB - 1);
      chk("deb_early", bus.player_pose, 2'b00);
      go(2 + DEB);
      chk("deb_lat", bus.player_pose, 2'b11);

      // 2: drop left arm, then bounce it
      bus.btn_left = 1'b0;
      t0 = cyc;
      go(t0 + 5);
      chk("left_down_early", bus.player_pose, 2'b11);
      go(t0 + 6);
      chk("left_down", bus.player_pose, 2'b01);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.btn_left = 1'b1;
         tick(); bad = bad | bus.player_pose[1];
         tick(); bad = bad | bus.player_pose[1];
         bus.btn_left = 1'b0;
         tick(); bad = bad | bus.player_pose[1];
         tick(); bad = bad | bus.player_pose[1];
      end
      chk("bounce_reject", bad, 0);
      bus.btn_left = 1'b1;
      t0 = cyc;
      go(t0 + 5);
      chk("bounce_settle_early", bus.player_pose[1], 0);
      go(t0 + 6);
      chk("bounce_settle", bus.player_pose[1], 1);

      // 3: RIGHTUP match, boss moves on during SETTLE
      do_reset(1'b0, 1'b1, 2'b01, 3);
      go(13);
      chk("m3_right_pre", bus.right, 0);
      go(14);
      chk("m3_right_on", bus.right, 1);
      chk("m3_busy_on", bus.busy, 1);
      go(15);
      chk("m3_right_2nd", bus.right, 1);
      go(16);
      chk("m3_right_off", bus.right, 0);
      chk("m3_busy_settle", bus.busy, 1);
      bus.boss_pose = 2'b10;
      go(17);
      chk("m3_busy_fall", bus.busy, 0);

      // 4: permanent mismatch -> periodic misses
      do_reset(1'b0, 1'b0, 2'b11, 3);
      go(99);
      chk("m4_miss99", bus.miss, 0);
      go(100);
      chk("m4_miss100", bus.miss, 1);
      go(101);
      chk("m4_miss101", bus.miss, 0);
      go(199);
      chk("m4_miss199", bus.miss, 0);
      go(200);
      chk("m4_miss200", bus.miss, 1);
      chk("m4_no_right", seen_right, 0);
`ifdef POSE_JUDGE_STREAK_EN
      chk("m4_streak", bus.streak, 0);
`endif

      // 5: hold completes on the timeout cycle
      do_reset(1'b0, 1'b0, 2'b11, 3);
      go(86);
      bus.btn_left = 1'b1;
      bus.btn_right = 1'b1;
      go(99);
      chk("m5_right99", bus.right, 0);
      go(100);
      chk("m5_right100", bus.right, 1);
      chk("m5_miss100", bus.miss, 0);
      go(101);
      chk("m5_miss101", seen_miss, 0);

      // 6: settle timeout, fresh hold, reset during PULSE
      do_reset(1'b0, 1'b0, 2'b00, 3);
      go(8);
      chk("m6_right8", bus.right, 1);
      go(25);
      chk("m6_busy25", bus.busy, 1);
      go(26);
      chk("m6_busy26", bus.busy, 0);
      go(33);
      chk("m6_right33", bus.right, 0);
      go(34);
      chk("m6_right34", bus.right, 1);
      reset = 1'b1;
      tick();
      chk("m6_rst_right", bus.right, 0);
      chk("m6_rst_busy", bus.busy, 0);

`ifdef POSE_JUDGE_STREAK_EN
      // three matches then a miss
      do_reset(1'b0, 1'b0, 2'b00, 3);
      go(60);
      chk("st_right60", bus.right, 1);
      chk("st_streak3", bus.streak, 3);
      chk("st_best3", bus.best, 3);
      bus.boss_pose = 2'b11;
      go(162);
      chk("st_streak162", bus.streak, 3);
      go(163);
      chk("st_miss163", bus.miss, 1);
      chk("st_streak0", bus.streak, 0);
      chk("st_best_kept", bus.best, 3);
`endif

      // randomized rounds
      for (int n = 0; n < 12; n++) begin
         p = 2'($urandom_range(0, 3));
         b = ($urandom_range(0, 1) == 1) ? p : 2'($urandom_range(0, 3));
         do_reset(p[1], p[0], b, 1);
         go(2 + DEB);
         chk("rnd_pose", bus.player_pose, p);
         re = exp_right_edge(p, b);
         if (re < 0) begin
            go(ROUND - 1);
            chk("rnd_miss_pre", bus.miss, 0);
            chk("rnd_no_right", seen_right, 0);
            go(ROUND);
            chk("rnd_miss", bus.miss, 1);
`ifdef POSE_JUDGE_STREAK_EN
            chk("rnd_streak0", bus.streak, 0);
`endif
         end else begin
            go(re - 1);
            chk("rnd_right_pre", bus.right, 0);
            go(re);
            chk("rnd_right_on", bus.right, 1);
`ifdef POSE_JUDGE_STREAK_EN
            chk("rnd_streak1", bus.streak, 1);
`endif
            go(re + PULSE - 1);
            chk("rnd_right_last", bus.right, 1);
            s = re + PULSE;
            go(s);
            chk("rnd_right_off", bus.right, 0);
            chk("rnd_busy_settle", bus.busy, 1);
            k = int'($urandom_range(0, 20));
            if (k < SETTLE) begin
               go(s + k);
               chk("rnd_busy_hold", bus.busy, 1);
               bus.boss_pose = b + 2'd1;
               go(s + k + 1);
               chk("rnd_busy_flip", bus.busy, 0);
            end else begin
               go(s + SETTLE - 1);
               chk("rnd_busy_hold", bus.busy, 1);
               go(s + SETTLE);
               chk("rnd_busy_tmo", bus.busy, 0);
            end
            chk("rnd_no_miss", seen_miss, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
